// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared constants for the unified-memory port arbiter.
// Holds the FSM state encoding, the access-owner code and the word-load
// read code driven to memory for instruction fetches. No ports.
package mem_arb_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_ACC = 2'd1;
    localparam logic [1:0] MA_ACC = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    typedef enum logic {OWN_IF = 1'b0, OWN_MA = 1'b1} owner_e;
    localparam logic [3:0] RD_WORD = 4'b1010;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the fetch, data-access and memory-side signals.
// master: arbiter view (drives rdata/busywaits to the requesters and MEM_* commands).
// slave:  environment view (cpu stages and memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic [DATA_W-1:0] IF_RDATA;
    logic              IF_BUSYWAIT;
    logic [3:0]        MA_READ;
    logic [2:0]        MA_WRITE;
    logic [ADDR_W-1:0] MA_ADDR;
    logic [DATA_W-1:0] MA_WDATA;
    logic [DATA_W-1:0] MA_RDATA;
    logic              MA_BUSYWAIT;
    logic [3:0]        MEM_READ;
    logic [2:0]        MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_BUSYWAIT;
    modport master (
        input  IF_REQ, IF_ADDR, MA_READ, MA_WRITE, MA_ADDR, MA_WDATA, MEM_RDATA, MEM_BUSYWAIT,
        output IF_RDATA, IF_BUSYWAIT, MA_RDATA, MA_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );
    modport slave (
        output IF_REQ, IF_ADDR, MA_READ, MA_WRITE, MA_ADDR, MA_WDATA, MEM_RDATA, MEM_BUSYWAIT,
        input  IF_RDATA, IF_BUSYWAIT, MA_RDATA, MA_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of fetch losses plus limit compare.
// Present only when MEM_ARB_STARVE_GUARD_EN is defined.
// Ports: CLK, RST (async active-low), inc (MA won while IF waited),
// clr (IF granted), at_limit (count has reached LIMIT).
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] if_wait_cnt_q, if_wait_cnt_d;
    always_comb
        if_wait_cnt_d = clr ? '0 : (inc && !at_limit) ? if_wait_cnt_q + 1'b1 : if_wait_cnt_q;
    always_ff @(posedge CLK or negedge RST)
        if (!RST) if_wait_cnt_q <= '0;
        else      if_wait_cnt_q <= if_wait_cnt_d;
    assign at_limit = if_wait_cnt_q == W'(LIMIT);
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF fetch and MA data access.
// Ports: CLK, RST (async active-low), bus (mem_port_arbiter_if.master: requester
// handshakes and the read-code/write-code/busywait memory port).
// MA has fixed priority; defining MEM_ARB_STARVE_GUARD_EN adds a fetch starvation
// guard that forces an IF grant after STARVE_LIMIT consecutive losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 4
`endif
) (
    input logic CLK,
    input logic RST,
    mem_port_arbiter_if.master bus
);
    logic [1:0]        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [3:0]        mem_read_q, mem_read_d;
    logic [2:0]        mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic ma_req, force_if, grant_ma, grant_if;

    assign ma_req   = (|bus.MA_READ) || (|bus.MA_WRITE);
    assign grant_ma = state_q == IDLE && ma_req && !force_if;
    assign grant_if = state_q == IDLE && bus.IF_REQ && !grant_ma;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic at_limit;
    mem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (grant_ma && bus.IF_REQ),
        .clr      (grant_if),
        .at_limit (at_limit)
    );
    assign force_if = at_limit && bus.IF_REQ;
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ma_rdata_d  = ma_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_ma) begin
                    state_d     = MA_ACC;
                    owner_d     = OWN_MA;
                    mem_read_d  = bus.MA_READ;
                    mem_write_d = bus.MA_WRITE;
                    mem_addr_d  = bus.MA_ADDR;
                    mem_wdata_d = bus.MA_WDATA;
                end else if (grant_if) begin
                    state_d     = IF_ACC;
                    owner_d     = OWN_IF;
                    mem_read_d  = RD_WORD;
                    mem_write_d = 3'd0;
                    mem_addr_d  = bus.IF_ADDR;
                    mem_wdata_d = '0;
                end
            end
            IF_ACC, MA_ACC: begin
                if (!bus.MEM_BUSYWAIT) begin
                    state_d     = RESP;
                    mem_read_d  = 4'd0;
                    mem_write_d = 3'd0;
                    if (state_q == IF_ACC) if_rdata_d = bus.MEM_RDATA;
                    else if (mem_read_q != 4'd0) ma_rdata_d = bus.MEM_RDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_read_q  <= '0;
            mem_write_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ma_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ma_rdata_q  <= ma_rdata_d;
        end
    end

    assign bus.MEM_READ    = mem_read_q;
    assign bus.MEM_WRITE   = mem_write_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_WDATA   = mem_wdata_q;
    assign bus.IF_RDATA    = if_rdata_q;
    assign bus.MA_RDATA    = ma_rdata_q;
    assign bus.IF_BUSYWAIT = bus.IF_REQ && !(state_q == RESP && owner_q == OWN_IF);
    assign bus.MA_BUSYWAIT = ma_req && !(state_q == RESP && owner_q == OWN_MA);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a cycle-count model.
module tb_mem_port_arbiter;
    logic CLK = 1'b0;
    logic RST;
    int total = 0;
    int bad = 0;
    int cnt = 0;
    logic hold_busy = 1'b0;
    logic cmd_act;
    logic [31:0] exp_if, exp_ma;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00500093 : ({a[15:0], ~a[15:0]} ^ 32'h1234_0000);
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        return int'(a[5:4]);
    endfunction

    assign cmd_act = (bus.MEM_READ != 4'd0) || (bus.MEM_WRITE != 3'd0);
    assign bus.MEM_RDATA = mem_val(bus.MEM_ADDR);
    assign bus.MEM_BUSYWAIT = cmd_act && (hold_busy || cnt < lat_of(bus.MEM_ADDR));
    always @(posedge CLK) cnt <= cmd_act ? cnt + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input logic di, input logic dm, input logic [3:0] rc, input logic [2:0] wc,
                           input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                           output int t_if, output int t_ma, output int wr_cyc);
        int t;
        int stab;
        logic own_ma;
        t = 0;
        stab = 0;
        t_if = -1;
        t_ma = -1;
        wr_cyc = 0;
        if (dm && rc != 4'd0) exp_ma = mem_val(ma);
        if (di) exp_if = mem_val(ia);
        bus.IF_REQ   = di;
        bus.IF_ADDR  = ia;
        bus.MA_READ  = dm ? rc : 4'd0;
        bus.MA_WRITE = dm ? wc : 3'd0;
        bus.MA_ADDR  = ma;
        bus.MA_WDATA = wd;
        while (((di && t_if < 0) || (dm && t_ma < 0)) && t < 60) begin
            @(negedge CLK);
            own_ma = dm && t_ma < 0;
            if (t == 1) begin
                chk("grant_read", 32'(bus.MEM_READ), own_ma ? 32'(rc) : 32'hA);
                chk("grant_write", 32'(bus.MEM_WRITE), own_ma ? 32'(wc) : 32'h0);
                chk("grant_addr", bus.MEM_ADDR, own_ma ? ma : ia);
            end
            if (cmd_act && (bus.MEM_ADDR !== (own_ma ? ma : ia) || (own_ma && bus.MEM_WDATA !== wd))) stab++;
            if (bus.MEM_WRITE != 3'd0) wr_cyc++;
            if (dm && t_ma < 0 && !bus.MA_BUSYWAIT) begin
                t_ma = t;
                chk("ma_rdata", bus.MA_RDATA, exp_ma);
            end
            if (di && t_if < 0 && !bus.IF_BUSYWAIT) begin
                t_if = t;
                chk("if_rdata", bus.IF_RDATA, exp_if);
            end
            @(posedge CLK);
            #1;
            if (t == 1 && dm) begin
                bus.MA_ADDR  = ma ^ 32'h0000_0ff0;
                bus.MA_WDATA = ~wd;
            end
            if (t == 1 && !dm) bus.IF_ADDR = ia ^ 32'h0000_0ff0;
            if (t_ma == t) begin
                bus.MA_READ  = 4'd0;
                bus.MA_WRITE = 3'd0;
            end
            if (t_if == t) bus.IF_REQ = 1'b0;
            t++;
        end
        chk("cmd_stable", 32'(stab), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti, tm, wcy, grants, if_idx, t, kind, li, lm;
        logic prev, ok, store, di, dm;
        logic [31:0] ia, ma, wd;
        logic [3:0] rc;
        logic [2:0] wc;
        RST = 1'b0;
        bus.IF_REQ = 1'b0;
        bus.IF_ADDR = '0;
        bus.MA_READ = '0;
        bus.MA_WRITE = '0;
        bus.MA_ADDR = '0;
        bus.MA_WDATA = '0;
        #1;
        chk("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
        chk("rst_mem_write", 32'(bus.MEM_WRITE), 32'd0);
        chk("rst_mem_addr", bus.MEM_ADDR, 32'd0);
        chk("rst_mem_wdata", bus.MEM_WDATA, 32'd0);
        chk("rst_if_rdata", bus.IF_RDATA, 32'd0);
        chk("rst_ma_rdata", bus.MA_RDATA, 32'd0);
        chk("rst_if_busy_idle", 32'(bus.IF_BUSYWAIT), 32'd0);
        bus.IF_REQ = 1'b1;
        #1;
        chk("rst_if_busy_req", 32'(bus.IF_BUSYWAIT), 32'd1);
        bus.IF_REQ = 1'b0;
        step;
        step;
        RST = 1'b1;
        step;
        exp_if = '0;
        exp_ma = '0;

        run_txn(1'b1, 1'b0, 4'd0, 3'd0, 32'h40, 32'h0, 32'h0, ti, tm, wcy);
        chk("if_only_done", 32'(ti), 32'd2);

        run_txn(1'b1, 1'b1, 4'b1010, 3'd0, 32'h80, 32'h100, 32'h0, ti, tm, wcy);
        chk("both_ma_done", 32'(tm), 32'd2);
        chk("both_if_lag", 32'(ti - tm), 32'd3);

        run_txn(1'b0, 1'b1, 4'd0, 3'b010, 32'h0, 32'h130, 32'hDEAD_BEEF, ti, tm, wcy);
        chk("store_done", 32'(tm), 32'd5);
        chk("store_write_cycles", 32'(wcy), 32'd4);

        grants = 0;
        if_idx = 0;
        prev = 1'b0;
        t = 0;
        bus.IF_REQ = 1'b1;
        bus.IF_ADDR = 32'h44;
        bus.MA_READ = 4'b0010;
        bus.MA_ADDR = 32'h200;
        while (grants < 8 && t < 80) begin
            @(negedge CLK);
            if (cmd_act && !prev) begin
                grants++;
                if (bus.MEM_READ == 4'b1010 && if_idx == 0) if_idx = grants;
            end
            prev = cmd_act;
            t++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_if_grant_idx", 32'(if_idx), 32'd5);
`else
        chk("starve_if_grant_idx", 32'(if_idx), 32'd0);
`endif
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLK);
            ok = !bus.MA_BUSYWAIT;
        end
        @(posedge CLK);
        #1;
        bus.MA_READ = 4'd0;
        for (int i = 0; i < 40 && ok; i++) begin
            @(negedge CLK);
            if (!bus.IF_BUSYWAIT) break;
            if (i == 39) ok = 1'b0;
        end
        @(posedge CLK);
        #1;
        bus.IF_REQ = 1'b0;
        chk("starve_drain", 32'(ok), 32'd1);
        exp_if = mem_val(32'h44);
        exp_ma = mem_val(32'h200);
        chk("starve_if_rdata", bus.IF_RDATA, exp_if);
        chk("starve_ma_rdata", bus.MA_RDATA, exp_ma);
        step;

        hold_busy = 1'b1;
        bus.MA_READ = 4'b1010;
        bus.MA_ADDR = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        chk("rstmid_pre_read", 32'(bus.MEM_READ), 32'hA);
        #2;
        RST = 1'b0;
        #1;
        chk("rstmid_mem_read", 32'(bus.MEM_READ), 32'd0);
        chk("rstmid_mem_write", 32'(bus.MEM_WRITE), 32'd0);
        chk("rstmid_mem_addr", bus.MEM_ADDR, 32'd0);
        chk("rstmid_mem_wdata", bus.MEM_WDATA, 32'd0);
        chk("rstmid_if_rdata", bus.IF_RDATA, 32'd0);
        chk("rstmid_ma_rdata", bus.MA_RDATA, 32'd0);
        chk("rstmid_ma_busy", 32'(bus.MA_BUSYWAIT), 32'd1);
        bus.MA_READ = 4'd0;
        hold_busy = 1'b0;
        exp_if = '0;
        exp_ma = '0;
        step;
        RST = 1'b1;
        step;
        run_txn(1'b1, 1'b0, 4'd0, 3'd0, 32'h50, 32'h0, 32'h0, ti, tm, wcy);
        chk("post_rst_if_done", 32'(ti), 32'd3);

        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 3);
            ia = $urandom & 32'hFFFF_FFFC;
            ma = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            rc = 4'($urandom_range(1, 15));
            wc = 3'($urandom_range(1, 7));
            store = kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1);
            di = kind == 0 || kind == 3;
            dm = kind != 0;
            li = lat_of(ia);
            lm = lat_of(ma);
            run_txn(di, dm, store ? 4'd0 : rc, store ? wc : 3'd0, ia, ma, wd, ti, tm, wcy);
            if (dm) chk("rand_ma_done", 32'(tm), 32'(2 + lm));
            if (kind == 0) chk("rand_if_done", 32'(ti), 32'(2 + li));
            if (kind == 3) chk("rand_if_after_ma", 32'(ti), 32'(tm + 3 + li));
            if (dm && store) chk("rand_write_cycles", 32'(wcy), 32'(lm + 1));
            repeat ($urandom_range(0, 2)) step;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
